// File: rtl/cu_pkg.sv
// Shared encodings for the ALU_System control unit: states, opcodes, function,
// mux and ALU codes, and the control-bus bundle driven each cycle.
package cu_pkg;

    typedef enum logic [2:0] {
        StInit,
        StFetchL,
        StFetchH,
        StExec1,
        StExec2,
        StHalt
    } state_t;

    localparam logic [3:0] OpLdi = 4'h0;
    localparam logic [3:0] OpLdm = 4'h1;
    localparam logic [3:0] OpSt  = 4'h2;
    localparam logic [3:0] OpAdd = 4'h3;
    localparam logic [3:0] OpSub = 4'h4;
    localparam logic [3:0] OpAnd = 4'h5;
    localparam logic [3:0] OpOr  = 4'h6;
    localparam logic [3:0] OpNot = 4'h7;
    localparam logic [3:0] OpLsl = 4'h8;
    localparam logic [3:0] OpLsr = 4'h9;
    localparam logic [3:0] OpMov = 4'hA;
    localparam logic [3:0] OpBra = 4'hB;
    localparam logic [3:0] OpBeq = 4'hC;
    localparam logic [3:0] OpBne = 4'hD;
    localparam logic [3:0] OpNop = 4'hE;
    localparam logic [3:0] OpHlt = 4'hF;

    // Register function codes, shared by RF, ARF and IR.
    localparam logic [1:0] FunDec   = 2'b00;
    localparam logic [1:0] FunInc   = 2'b01;
    localparam logic [1:0] FunLoad  = 2'b10;
    localparam logic [1:0] FunClear = 2'b11;

    localparam logic [1:0] MuxAluOut  = 2'b00;
    localparam logic [1:0] MuxMemOut  = 2'b01;
    localparam logic [1:0] MuxIrLow   = 2'b10;
    localparam logic [1:0] MuxArfOutC = 2'b11;

    localparam logic [3:0] AluPassA = 4'b0000;
    localparam logic [3:0] AluNotA  = 4'b0010;
    localparam logic [3:0] AluAdd   = 4'b0100;
    localparam logic [3:0] AluSub   = 4'b0110;
    localparam logic [3:0] AluAnd   = 4'b0111;
    localparam logic [3:0] AluOr    = 4'b1000;
    localparam logic [3:0] AluLsl   = 4'b1010;
    localparam logic [3:0] AluLsr   = 4'b1011;

    localparam logic [3:0] ArfSelPc  = 4'b1000;
    localparam logic [3:0] ArfSelAr  = 4'b0100;
    localparam logic [3:0] ArfSelAll = 4'b1110;

    localparam logic [1:0] AddrPc = 2'b00;
    localparam logic [1:0] AddrAr = 2'b01;
    localparam logic [1:0] AddrSp = 2'b10;

    typedef struct packed {
        logic [2:0] rf_out_a_sel;
        logic [2:0] rf_out_b_sel;
        logic [1:0] rf_fun_sel;
        logic [3:0] rf_r_sel;
        logic [3:0] alu_fun_sel;
        logic [1:0] arf_out_d_sel;
        logic [1:0] arf_fun_sel;
        logic [3:0] arf_reg_sel;
        logic       ir_lh;
        logic       ir_enable;
        logic [1:0] ir_fun_sel;
        logic       mem_wr;
        logic       mem_cs;
        logic [1:0] mux_a_sel;
        logic [1:0] mux_b_sel;
        logic       mux_c_sel;
        logic       halted;
    } ctrl_t;

    function automatic ctrl_t ctrl_idle();
        ctrl_t c;
        c        = '0;
        c.mem_cs = 1'b1;
        return c;
    endfunction

    // Register index 0..3 (R1..R4) to write enable, R1 on bit 3.
    function automatic logic [3:0] rf_onehot(input logic [1:0] r);
        return 4'b1000 >> r;
    endfunction

endpackage

// File: rtl/cu_alu_decode.sv
// Opcode to ALU function code; is_alu marks the ops whose flags get latched.
module cu_alu_decode
    import cu_pkg::*;
(
    input  logic [3:0] opcode,
    output logic [3:0] alu_fun_sel,
    output logic       is_alu
);

    always_comb begin
        alu_fun_sel = AluPassA;
        is_alu      = 1'b1;
        unique case (opcode)
            OpAdd:   alu_fun_sel = AluAdd;
            OpSub:   alu_fun_sel = AluSub;
            OpAnd:   alu_fun_sel = AluAnd;
            OpOr:    alu_fun_sel = AluOr;
            OpNot:   alu_fun_sel = AluNotA;
            OpLsl:   alu_fun_sel = AluLsl;
            OpLsr:   alu_fun_sel = AluLsr;
            default: is_alu = 1'b0;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Hardwired fetch/decode/execute sequencer for ALU_System. Outputs are
// combinational from the state, IROut and the latched flags.
module control_unit
    import cu_pkg::*;
#(
    parameter bit RESET_CLEARS_RF = 1'b1
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [15:0] IROut,
    input  logic [3:0] ALUOutFlag,
    output logic [2:0] RF_OutASel,
    output logic [2:0] RF_OutBSel,
    output logic [1:0] RF_FunSel,
    output logic [3:0] RF_RSel,
    output logic [3:0] RF_TSel,
    output logic [3:0] ALU_FunSel,
    output logic [1:0] ARF_OutCSel,
    output logic [1:0] ARF_OutDSel,
    output logic [1:0] ARF_FunSel,
    output logic [3:0] ARF_RegSel,
    output logic       IR_LH,
    output logic       IR_Enable,
    output logic [1:0] IR_Funsel,
    output logic       Mem_WR,
    output logic       Mem_CS,
    output logic [1:0] MuxASel,
    output logic [1:0] MuxBSel,
    output logic       MuxCSel,
    output logic       Halted
);

    state_t     state_q;
    logic [3:0] flags_q;  // {Z,C,N,O}
    ctrl_t      ctrl;

    logic [3:0] opcode;
    logic [1:0] rx, rs1, rs2;
    logic [3:0] alu_fun;
    logic       is_alu;
    logic       unused_bits;

    assign opcode      = IROut[15:12];
    assign rx          = IROut[9:8];
    assign rs1         = IROut[5:4];
    assign rs2         = IROut[1:0];
    assign unused_bits = ^{IROut[11:10], IROut[7:6], IROut[3:2], flags_q[2:0]};

    cu_alu_decode u_alu_decode (
        .opcode      (opcode),
        .alu_fun_sel (alu_fun),
        .is_alu      (is_alu)
    );

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= StInit;
            flags_q <= 4'b0000;
        end else begin
            unique case (state_q)
                StInit:   state_q <= StFetchL;
                StFetchL: state_q <= StFetchH;
                StFetchH: state_q <= StExec1;
                StExec1: begin
                    if (opcode == OpHlt) begin
                        state_q <= StHalt;
                    end else if (opcode == OpLdm || opcode == OpSt) begin
                        state_q <= StExec2;
                    end else begin
                        state_q <= StFetchL;
                    end
                    if (is_alu) begin
                        flags_q <= ALUOutFlag;
                    end
                end
                StExec2:  state_q <= StFetchL;
                StHalt:   state_q <= StHalt;
                default:  state_q <= StInit;
            endcase
        end
    end

    always_comb begin
        ctrl = ctrl_idle();
        unique case (state_q)
            StInit: begin
                ctrl.arf_reg_sel = ArfSelAll;
                ctrl.arf_fun_sel = FunClear;
                if (RESET_CLEARS_RF) begin
                    ctrl.rf_r_sel   = 4'b1111;
                    ctrl.rf_fun_sel = FunClear;
                end
            end
            StFetchL, StFetchH: begin
                ctrl.arf_out_d_sel = AddrPc;
                ctrl.mem_cs        = 1'b0;
                ctrl.ir_enable     = 1'b1;
                ctrl.ir_fun_sel    = FunLoad;
                ctrl.ir_lh         = (state_q == StFetchH);
                ctrl.arf_reg_sel   = ArfSelPc;
                ctrl.arf_fun_sel   = FunInc;
            end
            StExec1: begin
                if (is_alu) begin
                    ctrl.rf_out_a_sel = {1'b0, rs1};
                    ctrl.rf_out_b_sel = {1'b0, rs2};
                    ctrl.mux_a_sel    = MuxAluOut;
                    ctrl.rf_r_sel     = rf_onehot(rx);
                    ctrl.rf_fun_sel   = FunLoad;
                    ctrl.alu_fun_sel  = alu_fun;
                end
                case (opcode)
                    OpLdi: begin
                        ctrl.mux_a_sel  = MuxIrLow;
                        ctrl.rf_r_sel   = rf_onehot(rx);
                        ctrl.rf_fun_sel = FunLoad;
                    end
                    OpLdm, OpSt: begin
                        ctrl.mux_b_sel   = MuxIrLow;
                        ctrl.arf_reg_sel = ArfSelAr;
                        ctrl.arf_fun_sel = FunLoad;
                    end
                    OpMov: begin
                        ctrl.rf_out_a_sel = {1'b0, rs1};
                        ctrl.mux_a_sel    = MuxAluOut;
                        ctrl.rf_r_sel     = rf_onehot(rx);
                        ctrl.rf_fun_sel   = FunLoad;
                    end
                    OpBra, OpBeq, OpBne: begin
                        // Conditional branches test the Z flag of the last ALU op.
                        if (opcode == OpBra || (opcode == OpBeq) == flags_q[3]) begin
                            ctrl.mux_b_sel   = MuxIrLow;
                            ctrl.arf_reg_sel = ArfSelPc;
                            ctrl.arf_fun_sel = FunLoad;
                        end
                    end
                    default: ;
                endcase
            end
            StExec2: begin
                ctrl.arf_out_d_sel = AddrAr;
                ctrl.mem_cs        = 1'b0;
                if (opcode == OpLdm) begin
                    ctrl.mux_a_sel  = MuxMemOut;
                    ctrl.rf_r_sel   = rf_onehot(rx);
                    ctrl.rf_fun_sel = FunLoad;
                end else begin
                    ctrl.mem_wr       = 1'b1;
                    ctrl.rf_out_a_sel = {1'b0, rx};
                    ctrl.mux_c_sel    = 1'b0;
                    ctrl.alu_fun_sel  = AluPassA;
                end
            end
            StHalt:  ctrl.halted = 1'b1;
            default: ;
        endcase
    end

    assign RF_OutASel  = ctrl.rf_out_a_sel;
    assign RF_OutBSel  = ctrl.rf_out_b_sel;
    assign RF_FunSel   = ctrl.rf_fun_sel;
    assign RF_RSel     = ctrl.rf_r_sel;
    assign RF_TSel     = 4'b0000;
    assign ALU_FunSel  = ctrl.alu_fun_sel;
    assign ARF_OutCSel = 2'b00;
    assign ARF_OutDSel = ctrl.arf_out_d_sel;
    assign ARF_FunSel  = ctrl.arf_fun_sel;
    assign ARF_RegSel  = ctrl.arf_reg_sel;
    assign IR_LH       = ctrl.ir_lh;
    assign IR_Enable   = ctrl.ir_enable;
    assign IR_Funsel   = ctrl.ir_fun_sel;
    assign Mem_WR      = ctrl.mem_wr;
    assign Mem_CS      = ctrl.mem_cs;
    assign MuxASel     = ctrl.mux_a_sel;
    assign MuxBSel     = ctrl.mux_b_sel;
    assign MuxCSel     = ctrl.mux_c_sel;
    assign Halted      = ctrl.halted;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: expected control words are queued per cycle
// from an instruction-level model and compared by an independent monitor.
module tb_control_unit;

    typedef struct packed {
        logic [2:0] a_sel;
        logic [2:0] b_sel;
        logic [1:0] rf_fun;
        logic [3:0] rsel;
        logic [3:0] tsel;
        logic [3:0] alu;
        logic [1:0] outc;
        logic [1:0] outd;
        logic [1:0] arf_fun;
        logic [3:0] arf_reg;
        logic       ir_lh;
        logic       ir_en;
        logic [1:0] ir_fun;
        logic       wr;
        logic       cs;
        logic [1:0] mux_a;
        logic [1:0] mux_b;
        logic       mux_c;
        logic       halted;
    } word_t;

    typedef struct {
        word_t w;
        string tag;
    } exp_t;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [15:0] IROut;
    logic [3:0]  ALUOutFlag;
    logic [2:0]  RF_OutASel, RF_OutBSel;
    logic [1:0]  RF_FunSel;
    logic [3:0]  RF_RSel, RF_TSel, ALU_FunSel;
    logic [1:0]  ARF_OutCSel, ARF_OutDSel, ARF_FunSel;
    logic [3:0]  ARF_RegSel;
    logic        IR_LH, IR_Enable;
    logic [1:0]  IR_Funsel;
    logic        Mem_WR, Mem_CS;
    logic [1:0]  MuxASel, MuxBSel;
    logic        MuxCSel, Halted;

    word_t act;
    exp_t  exp_q[$];
    int    n_checks = 0;
    int    n_errors = 0;
    logic  z_m = 1'b0;

    always #5 Clock = ~Clock;

    control_unit #(.RESET_CLEARS_RF(1'b1)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .IROut       (IROut),
        .ALUOutFlag  (ALUOutFlag),
        .RF_OutASel  (RF_OutASel),
        .RF_OutBSel  (RF_OutBSel),
        .RF_FunSel   (RF_FunSel),
        .RF_RSel     (RF_RSel),
        .RF_TSel     (RF_TSel),
        .ALU_FunSel  (ALU_FunSel),
        .ARF_OutCSel (ARF_OutCSel),
        .ARF_OutDSel (ARF_OutDSel),
        .ARF_FunSel  (ARF_FunSel),
        .ARF_RegSel  (ARF_RegSel),
        .IR_LH       (IR_LH),
        .IR_Enable   (IR_Enable),
        .IR_Funsel   (IR_Funsel),
        .Mem_WR      (Mem_WR),
        .Mem_CS      (Mem_CS),
        .MuxASel     (MuxASel),
        .MuxBSel     (MuxBSel),
        .MuxCSel     (MuxCSel),
        .Halted      (Halted)
    );

    assign act = {RF_OutASel, RF_OutBSel, RF_FunSel, RF_RSel, RF_TSel, ALU_FunSel,
                  ARF_OutCSel, ARF_OutDSel, ARF_FunSel, ARF_RegSel, IR_LH, IR_Enable,
                  IR_Funsel, Mem_WR, Mem_CS, MuxASel, MuxBSel, MuxCSel, Halted};

    function automatic word_t idle_w();
        word_t w;
        w    = '0;
        w.cs = 1'b1;
        return w;
    endfunction

    function automatic word_t init_w();
        word_t w;
        w         = idle_w();
        w.arf_reg = 4'b1110;
        w.arf_fun = 2'b11;
        w.rsel    = 4'b1111;
        w.rf_fun  = 2'b11;
        return w;
    endfunction

    function automatic word_t fetch_w(input logic hi);
        word_t w;
        w         = idle_w();
        w.cs      = 1'b0;
        w.ir_en   = 1'b1;
        w.ir_fun  = 2'b10;
        w.ir_lh   = hi;
        w.arf_reg = 4'b1000;
        w.arf_fun = 2'b01;
        return w;
    endfunction

    function automatic word_t halt_w();
        word_t w;
        w        = idle_w();
        w.halted = 1'b1;
        return w;
    endfunction

    // Instruction semantics: what each opcode asks of the datapath in each execute cycle.
    function automatic word_t exec_w(input logic [15:0] ir, input int stage, input logic z);
        word_t      w;
        logic [3:0] wen [4];
        logic [3:0] alu_tab [7];
        int         op;
        logic [1:0] rx, rs1, rs2;
        wen     = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
        alu_tab = '{4'b0100, 4'b0110, 4'b0111, 4'b1000, 4'b0010, 4'b1010, 4'b1011};
        op  = int'(ir[15:12]);
        rx  = ir[9:8];
        rs1 = ir[5:4];
        rs2 = ir[1:0];
        w   = idle_w();
        if (stage == 1) begin
            if (op == 0) begin
                w.mux_a = 2'b10; w.rsel = wen[rx]; w.rf_fun = 2'b10;
            end else if (op == 1 || op == 2) begin
                w.mux_b = 2'b10; w.arf_reg = 4'b0100; w.arf_fun = 2'b10;
            end else if (op >= 3 && op <= 9) begin
                w.a_sel = {1'b0, rs1}; w.b_sel = {1'b0, rs2};
                w.rsel = wen[rx]; w.rf_fun = 2'b10; w.alu = alu_tab[op - 3];
            end else if (op == 10) begin
                w.a_sel = {1'b0, rs1}; w.rsel = wen[rx]; w.rf_fun = 2'b10;
            end else if (op == 11 || (op == 12 && z) || (op == 13 && !z)) begin
                w.mux_b = 2'b10; w.arf_reg = 4'b1000; w.arf_fun = 2'b10;
            end
        end else begin
            if (op == 1) begin
                w.outd = 2'b01; w.cs = 1'b0; w.mux_a = 2'b01;
                w.rsel = wen[rx]; w.rf_fun = 2'b10;
            end else if (op == 2) begin
                w.outd = 2'b01; w.cs = 1'b0; w.wr = 1'b1; w.a_sel = {1'b0, rx};
            end
        end
        return w;
    endfunction

    task automatic check_word(input string tag, input word_t a, input word_t e);
        logic [42:0] av, ev;
        av = a;
        ev = e;
        n_checks++;
        if (av !== ev) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, av, ev);
        end
    endtask

    // One clock cycle of stimulus; the expected word applies until the next edge.
    task automatic cyc(input word_t e, input logic [3:0] f, input string tag);
        exp_t x;
        @(posedge Clock);
        #1;
        ALUOutFlag = f;
        x.w   = e;
        x.tag = tag;
        exp_q.push_back(x);
    endtask

    task automatic run_instr(input logic [15:0] ir, input logic [3:0] f1, input string tag);
        int op;
        op = int'(ir[15:12]);
        cyc(fetch_w(1'b0), 4'($urandom), {tag, "_fetch_l"});
        IROut = ir;
        cyc(fetch_w(1'b1), 4'($urandom), {tag, "_fetch_h"});
        cyc(exec_w(ir, 1, z_m), f1, {tag, "_exec1"});
        if (op >= 3 && op <= 9) z_m = f1[3];
        if (op == 1 || op == 2) cyc(exec_w(ir, 2, z_m), 4'($urandom), {tag, "_exec2"});
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge Clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_word(e.tag, act, e.w);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timed out");
    end

    initial begin : stimulus
        logic [15:0] ir;
        Reset      = 1'b0;
        IROut      = 16'h0000;
        ALUOutFlag = 4'h0;
        #1;
        check_word("reset_async", act, init_w());
        repeat (3) cyc(init_w(), 4'($urandom), "reset_low");
        Reset = 1'b1;

        run_instr(16'h0155, 4'($urandom), "ldi");
        run_instr(16'h3112, 4'b1000, "add_z1");
        run_instr(16'hC020, 4'($urandom), "beq_taken");
        run_instr(16'hD020, 4'($urandom), "bne_not_taken");
        run_instr(16'h3112, 4'b0000, "add_z0");
        run_instr(16'hC020, 4'($urandom), "beq_idle");
        run_instr(16'h0155, 4'b1111, "ldi_keep_flags");
        run_instr(16'hD0FF, 4'($urandom), "bne_old_flags");
        run_instr(16'h1280, 4'($urandom), "ldm");

        for (int i = 0; i < 250; i++) begin
            ir = 16'($urandom);
            if (ir[15:12] == 4'hF) ir[15:12] = 4'hE;
            run_instr(ir, 4'($urandom), "rand");
        end

        // Reset in the ST write cycle must drop Mem_WR without waiting for a clock.
        run_instr(16'h2340, 4'($urandom), "st");
        @(negedge Clock);
        #2;
        Reset = 1'b0;
        #1;
        check_word("reset_mid_st", act, init_w());
        n_checks++;
        if (Mem_WR !== 1'b0) begin
            n_errors++;
            $display("FAIL st_wr_drop: got %b expected 0", Mem_WR);
        end
        z_m = 1'b0;
        cyc(init_w(), 4'($urandom), "st_reset_init");
        Reset = 1'b1;
        run_instr(16'hC010, 4'($urandom), "beq_after_reset");

        run_instr(16'hF000, 4'($urandom), "hlt");
        repeat (20) cyc(halt_w(), 4'($urandom), "halted");
        cyc(init_w(), 4'($urandom), "halt_reset");
        Reset = 1'b0;
        z_m = 1'b0;
        cyc(init_w(), 4'($urandom), "halt_reset_init");
        Reset = 1'b1;
        run_instr(16'h0155, 4'($urandom), "ldi_after_halt");

        @(negedge Clock);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
